switch_debounce_2ch: RTL and testbench

//  Two-channel switch conditioner sitting directly upstream of the 2-input AND gate.

---
 rtl/switch_debounce_2ch.sv | 95 +++++++++
 tb/tb_switch_debounce_2ch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_2ch.sv
// switch_debounce_2ch: two independent synchronise-and-debounce channels producing clean levels
// plus one-cycle rise/fall strobes for the downstream AND gate and counters.
module switch_debounce_2ch #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_in,
    input  logic sw_b_in,
    output logic a_out,
    output logic b_out,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    typedef enum logic {STABLE, CHECK} state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CNT < 2) begin : g_bad_cnt
        $error("STABLE_CNT must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(STABLE_CNT)) begin : g_bad_w
        $error("CNT_W too narrow for STABLE_CNT");
    end

    logic [1:0] w_raw, w_lvl, w_rise, w_fall;

    assign w_raw = {sw_b_in, sw_a_in};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        state_t                 r_state;
        logic                   r_lvl, r_rise, r_fall;
        logic                   w_sync, w_diff;

        assign w_sync = r_sync[SYNC_STAGES-1];
        assign w_diff = w_sync != r_lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sync <= '0;
            else        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[c]};
        end

        // Counter never exceeds STABLE_CNT-1: reaching it either accepts the level or the
        // mismatch vanished, and both paths clear it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= STABLE;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    STABLE: if (w_diff) begin
                        r_state <= CHECK;
                        r_cnt   <= CNT_W'(1);
                    end
                    CHECK: if (!w_diff) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(STABLE_CNT - 1)) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                        r_lvl   <= w_sync;
                        r_rise  <= w_sync;
                        r_fall  <= !w_sync;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: r_state <= STABLE;
                endcase
            end
        end

        assign w_lvl[c]  = r_lvl;
        assign w_rise[c] = r_rise;
        assign w_fall[c] = r_fall;
    end

    assign a_out  = w_lvl[0];
    assign b_out  = w_lvl[1];
    assign a_rise = w_rise[0];
    assign a_fall = w_fall[0];
    assign b_rise = w_rise[1];
    assign b_fall = w_fall[1];
endmodule

// File: tb/tb_switch_debounce_2ch.sv
// tb_switch_debounce_2ch: directed and random switch stimulus against a sliding-window
// debounce model; expected strobes are queued and matched by an independent monitor.
module tb_switch_debounce_2ch;
    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 0;
    logic rst_n = 0;
    logic sw_a = 0, sw_b = 0;
    logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {int cyc; bit rise;} ev_t;
    ev_t q0[$], q1[$];
    bit  h0[$], h1[$];
    bit  exp_lvl[2];

    switch_debounce_2ch #(.SYNC_STAGES(SS), .STABLE_CNT(SC), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw_a_in(sw_a), .sw_b_in(sw_b),
        .a_out(a_out), .b_out(b_out), .a_rise(a_rise), .a_fall(a_fall),
        .b_rise(b_rise), .b_fall(b_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Post-sync sample seen k edges ago (k=0 newest); samples from before reset read as 0.
    function automatic bit seen(input bit h[$], input int k);
        int idx = h.size() - 1 - SS - k;
        return idx < 0 ? 1'b0 : h[idx];
    endfunction

    // Level flips once the last SC post-sync samples all disagree with it.
    function automatic bit flips(input bit h[$], input bit lvl);
        for (int k = 0; k < SC; k++)
            if (seen(h, k) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0.delete(); h1.delete(); q0.delete(); q1.delete();
            exp_lvl[0] <= 1'b0;
            exp_lvl[1] <= 1'b0;
        end else begin
            h0.push_back(sw_a);
            h1.push_back(sw_b);
            if (h0.size() > 32) begin void'(h0.pop_front()); void'(h1.pop_front()); end
            if (flips(h0, exp_lvl[0])) begin
                q0.push_back('{cyc + 1, !exp_lvl[0]});
                exp_lvl[0] <= !exp_lvl[0];
            end
            if (flips(h1, exp_lvl[1])) begin
                q1.push_back('{cyc + 1, !exp_lvl[1]});
                exp_lvl[1] <= !exp_lvl[1];
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        chk(a_out == exp_lvl[0], "a_out", a_out, exp_lvl[0]);
        chk(b_out == exp_lvl[1], "b_out", b_out, exp_lvl[1]);
        chk((a_out & b_out) == (exp_lvl[0] & exp_lvl[1]), "and_f", a_out & b_out, exp_lvl[0] & exp_lvl[1]);
        chk(!(a_rise && a_fall), "a_strobe_excl", a_rise + a_fall, 1);
        chk(!(b_rise && b_fall), "b_strobe_excl", b_rise + b_fall, 1);
        if (a_rise || a_fall) begin
            if (q0.size() == 0) chk(0, "a_spurious_strobe", a_rise, 0);
            else begin
                e = q0.pop_front();
                chk(e.cyc == cyc, "a_strobe_cycle", cyc, e.cyc);
                chk(e.rise == a_rise, "a_strobe_kind", a_rise, e.rise);
            end
        end
        if (b_rise || b_fall) begin
            if (q1.size() == 0) chk(0, "b_spurious_strobe", b_rise, 0);
            else begin
                e = q1.pop_front();
                chk(e.cyc == cyc, "b_strobe_cycle", cyc, e.cyc);
                chk(e.rise == b_rise, "b_strobe_kind", b_rise, e.rise);
            end
        end
        while (q0.size() > 0 && q0[0].cyc <= cyc) begin
            chk(0, "a_missed_strobe", 0, q0[0].cyc);
            void'(q0.pop_front());
        end
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            chk(0, "b_missed_strobe", 0, q1[0].cyc);
            void'(q1.pop_front());
        end
    end

    task automatic drive(input bit a, input bit b, input int n);
        sw_a = a;
        sw_b = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edges_to_a_rise(input string name);
        int n = 0;
        bit seen_rise = 0;
        while (n < 20 && !seen_rise) begin
            @(posedge clk);
            #1;
            n++;
            seen_rise = a_rise;
        end
        chk(seen_rise && n == SS + SC, name, n, SS + SC);
    endtask

    initial begin
        sw_a = 1; sw_b = 1;
        repeat (5) @(posedge clk);
        #1;
        drive(0, 0, 1);
        rst_n = 1;
        drive(0, 0, 8);
        sw_a = 1;
        edges_to_a_rise("clean_step_latency");
        drive(1, 0, 4);
        drive(0, 0, 10);
        drive(1, 0, 1); drive(0, 0, 1); drive(1, 0, 1); drive(0, 0, 1);
        sw_a = 1;
        edges_to_a_rise("bounce_latency");
        drive(1, 0, 4);
        drive(0, 0, 10);
        drive(0, 1, 3);
        drive(0, 0, 10);
        drive(1, 1, 10);
        drive(0, 0, 10);
        for (int i = 0; i < 4; i++) drive(i[0], i[1], 8);
        drive(0, 0, 10);
        sw_a = 1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        edges_to_a_rise("reset_midcount_latency");
        drive(0, 0, 10);
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 0;
                drive(sw_a, sw_b, $urandom_range(1, 2));
                rst_n = 1;
            end
        end
        drive(0, 0, 12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
